// File: rtl/mtx_writeback.sv
// Result write-back engine: streams an m x p product matrix row-major into memory,
// packing EPW elements per 32-bit word and holding each word until memory accepts it.
module mtx_writeback #(
    parameter int unsigned BITS = 8,
    parameter int unsigned DIM  = 32
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic [$clog2(DIM):0]                m,
    input  logic [$clog2(DIM):0]                p,
    input  logic [31:0]                         base_addr,
    input  logic [DIM-1:0][DIM-1:0][2*BITS-1:0] data_in,
    input  logic                                MemStall,
    output logic [31:0]                         MemAddr,
    output logic [31:0]                         MemWrData,
    output logic                                MemEn,
    output logic                                MemWrEn,
    output logic                                busy,
    output logic                                done,
    output logic                                err
);

    localparam int unsigned EW  = 2 * BITS;
    localparam int unsigned EPW = 32 / EW;
    localparam int unsigned MW  = $clog2(DIM) + 1;
    localparam int unsigned RW  = $clog2(DIM + EPW + 1) + 1;
    localparam int unsigned IW  = (DIM > 1) ? $clog2(DIM) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t        r_state, w_nxt_state;
    logic [MW-1:0] r_m, r_p, w_nxt_m, w_nxt_p;
    logic [RW-1:0] r_row, w_nxt_row;
    logic [MW-1:0] r_col, w_nxt_col;
    logic [31:0]   r_addr, w_nxt_addr;
    logic          r_busy, r_done, r_err;
    logic          w_nxt_done, w_nxt_err;

    logic [RW-1:0] w_row [EPW+1];
    logic [MW-1:0] w_col [EPW+1];
    logic [31:0]   w_pack;
    logic          w_bad_dim;

    // Walk the cursor EPW steps; lanes whose row has run past m are zero padding.
    always_comb begin
        w_row[0] = r_row;
        w_col[0] = r_col;
        w_pack   = '0;
        for (int i = 0; i < EPW; i++) begin
            if (w_col[i] == MW'(r_p - MW'(1))) begin
                w_col[i+1] = '0;
                w_row[i+1] = RW'(w_row[i] + RW'(1));
            end else begin
                w_col[i+1] = MW'(w_col[i] + MW'(1));
                w_row[i+1] = w_row[i];
            end
            if (w_row[i] < RW'(r_m)) begin
                w_pack[i*EW +: EW] = data_in[IW'(w_row[i])][IW'(w_col[i])];
            end
        end
    end

    assign w_bad_dim = (m == '0) || (m > MW'(DIM)) || (p == '0) || (p > MW'(DIM));

    // Next-state, counter and registered-output decode.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_m     = r_m;
        w_nxt_p     = r_p;
        w_nxt_row   = r_row;
        w_nxt_col   = r_col;
        w_nxt_addr  = r_addr;
        w_nxt_done  = 1'b0;
        w_nxt_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_bad_dim) begin
                        w_nxt_err = 1'b1;
                    end else begin
                        w_nxt_m     = m;
                        w_nxt_p     = p;
                        w_nxt_row   = '0;
                        w_nxt_col   = '0;
                        w_nxt_addr  = base_addr;
                        w_nxt_state = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (!MemStall) begin
                    w_nxt_row  = w_row[EPW];
                    w_nxt_col  = w_col[EPW];
                    w_nxt_addr = r_addr + 32'd4;
                    // Word is last when the cursor after it lies beyond the final row.
                    if (w_row[EPW] >= RW'(r_m)) begin
                        w_nxt_addr  = '0;
                        w_nxt_done  = 1'b1;
                        w_nxt_state = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_nxt_state = S_IDLE;
            end
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_addr  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_m     <= '0;
            r_p     <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_addr  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_m     <= w_nxt_m;
            r_p     <= w_nxt_p;
            r_row   <= w_nxt_row;
            r_col   <= w_nxt_col;
            r_addr  <= w_nxt_addr;
            r_busy  <= (w_nxt_state == S_WRITE);
            r_done  <= w_nxt_done;
            r_err   <= w_nxt_err;
        end
    end

    assign MemAddr   = r_addr;
    assign MemWrData = r_busy ? w_pack : 32'd0;
    assign MemEn     = r_busy;
    assign MemWrEn   = r_busy;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule
